wishbone_req_queue: RTL and testbench
=====================================

WISHBONE_REQ_QUEUE -- requirements
Module: wishbone_req_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the request FIFO entries; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have the core request ports, all inputs: req_valid_i (1), req_addr_i (32), req_data_i (32), req_we_i (4, byte write enables, 0 = read) and req_naccess_i (3, access count).
REQ-005 The block SHALL have port req_ready_o, output, 1 bit: the FIFO can accept a request this cycle.
REQ-006 The block SHALL have the core response ports: rsp_valid_o (output, 1), rsp_data_o (output, 32) and rsp_ready_i (input, 1).
REQ-007 The block SHALL drive the wishbone_master request side, all outputs: mst_addr_o (32), mst_data_o (32), mst_we_o (4), mst_naccess_o (3) and mst_valid_o (1).
REQ-008 The block SHALL receive the wishbone_master completion side, all inputs: mst_data_i (32) and mst_valid_i (1, one-cycle completion pulse).

Function
REQ-009 The block SHALL accept a request on a rising edge where req_valid_i && req_ready_o, writing {addr, data, we, naccess} to the FIFO tail.
REQ-010 The block SHALL drive req_ready_o = !full, combinationally from the occupancy count, which is $clog2(DEPTH)+1 bits wide.
REQ-011 The FIFO pointers SHALL wrap modulo DEPTH, and full SHALL be defined as count == DEPTH.
REQ-012 A push and a pop in the same cycle SHALL leave count unchanged, and the pushed entry SHALL be stored correctly.
REQ-013 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-014 IDLE: if the FIFO is non-empty, the block SHALL pop the head into the issue register and go to BUSY; otherwise it SHALL stay in IDLE.
REQ-015 BUSY: the block SHALL hold mst_valid_o=1 and hold the mst_* fields stable from the issue register until mst_valid_i=1.
REQ-016 BUSY with mst_valid_i=1: the block SHALL capture mst_data_i into rsp_data_o, clear mst_valid_o on the next edge and go to RESP.
REQ-017 RESP: the block SHALL hold rsp_valid_o=1 and rsp_data_o stable until rsp_ready_i=1, then go to IDLE.
REQ-018 Every request, read or write, SHALL produce exactly one response; for writes, rsp_data_o carries whatever mst_data_i held at completion.
REQ-019 The block SHALL have at most one request outstanding at the master, and SHALL issue requests in FIFO order.
REQ-020 Minimum latency SHALL be: push edge t, then pop at t+1, then mst_valid_o=1 from t+2; with completion at edge c, rsp_valid_o=1 from c+1.
REQ-021 The block SHALL ignore mst_valid_i in IDLE and RESP (no state change, no data capture).
REQ-022 The FIFO SHALL keep accepting pushes while the FSM is in BUSY or RESP, until it is full.

Reset
REQ-023 On rst_i=1 the block SHALL immediately clear state to IDLE, pointers and count to 0, mst_valid_o=0, rsp_valid_o=0, rsp_data_o=0 and mst_* fields=0, with req_ready_o following count=0 (ready=1).
REQ-024 Reset asserted mid-transaction SHALL discard all queued and in-flight requests, and no response SHALL be produced for them after reset.

Structure
REQ-025 Package wb_req_pkg SHALL hold typedef wb_req_t {addr[31:0], data[31:0], we[3:0], naccess[2:0]} and the widths WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4 and WB_NACC_W=3.
REQ-026 The FIFO SHALL be sub-module wb_req_fifo, parameterised by DEPTH and element type wb_req_t, with the FSM and response register in the top module.

Verification
REQ-027 Single read test: push addr=0x04, we=0; master completes 3 cycles after mst_valid_o rises with data 0xDEADBEEF; then rsp_valid_o=1 with rsp_data_o=0xDEADBEEF, and mst_valid_o is high for exactly 4 cycles.
REQ-028 Fill test: push 5 requests back-to-back with master stalled (DEPTH=4); then the first request is in the issue register, 4 entries are queued and req_ready_o=0 after the fifth push; after the next completion plus pop, req_ready_o=1.
REQ-029 Ordering test: push writes to 0x00, 0x04, 0x10, 0x14; then mst_addr_o sequence is 0x00, 0x04, 0x10, 0x14 with 4 responses in order.
REQ-030 Response backpressure test: hold rsp_ready_i=0 for 10 cycles after completion; then rsp_valid_o and rsp_data_o stay stable, and mst_valid_o stays 0 for the next entry until rsp_ready_i=1.
REQ-031 Spurious completion test: pulse mst_valid_i in IDLE with 0x12345678; then rsp_valid_o stays 0 and rsp_data_o is unchanged.
REQ-032 Reset-mid-BUSY test: with 2 entries queued, assert rst_i between clock edges; then mst_valid_o=0, req_ready_o=1 and count=0 without waiting for a clock edge, and no rsp_valid_o after release.

Source files
------------

// File: rtl/wb_req_pkg.sv
// wb_req_pkg: shared widths, request record and FSM state type for the wishbone request queue.
package wb_req_pkg;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_NACC_W = 3;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_SEL_W-1:0]  we;
        logic [WB_NACC_W-1:0] naccess;
    } wb_req_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/wb_req_fifo.sv
// wb_req_fifo: power-of-two circular request FIFO with an occupancy count driving full/empty.
module wb_req_fifo
    import wb_req_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_req_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);
    localparam int AW = $clog2(DEPTH);

    T               r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;

    // Storage stays out of the reset domain; only pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/wishbone_req_queue.sv
// wishbone_req_queue: buffers core requests and issues them one at a time to a wishbone master,
// returning exactly one response per request in FIFO order.
module wishbone_req_queue
    import wb_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [WB_ADDR_W-1:0] req_addr_i,
    input  logic [WB_DATA_W-1:0] req_data_i,
    input  logic [WB_SEL_W-1:0]  req_we_i,
    input  logic [WB_NACC_W-1:0] req_naccess_i,
    output logic                 req_ready_o,
    output logic                 rsp_valid_o,
    output logic [WB_DATA_W-1:0] rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic [WB_ADDR_W-1:0] mst_addr_o,
    output logic [WB_DATA_W-1:0] mst_data_o,
    output logic [WB_SEL_W-1:0]  mst_we_o,
    output logic [WB_NACC_W-1:0] mst_naccess_o,
    output logic                 mst_valid_o,
    input  logic [WB_DATA_W-1:0] mst_data_i,
    input  logic                 mst_valid_i
);
    wb_req_t              w_head;
    wb_req_t              r_issue;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    state_t               r_state;
    logic                 r_mst_valid;
    logic                 r_rsp_valid;
    logic [WB_DATA_W-1:0] r_rsp_data;

    assign req_ready_o = !w_full;
    assign w_pop       = (r_state == IDLE) && !w_empty;

    wb_req_fifo #(.DEPTH(DEPTH), .T(wb_req_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (req_valid_i && !w_full),
        .i_data  ({req_addr_i, req_data_i, req_we_i, req_naccess_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // mst_valid_i is only honoured in BUSY, so stray completions cannot disturb the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_issue     <= '0;
            r_mst_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_pop) begin
                    r_issue     <= w_head;
                    r_mst_valid <= 1'b1;
                    r_state     <= BUSY;
                end
                BUSY: if (mst_valid_i) begin
                    r_rsp_data  <= mst_data_i;
                    r_mst_valid <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: if (rsp_ready_i) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mst_addr_o    = r_issue.addr;
    assign mst_data_o    = r_issue.data;
    assign mst_we_o      = r_issue.we;
    assign mst_naccess_o = r_issue.naccess;
    assign mst_valid_o   = r_mst_valid;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
endmodule

// File: tb/tb_wishbone_req_queue.sv
// tb_wishbone_req_queue: scenario tasks with a request/response scoreboard for wishbone_req_queue.
module tb_wishbone_req_queue;
    import wb_req_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_we_i = '0;
    logic [2:0]  req_naccess_i = '0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] mst_addr_o;
    logic [31:0] mst_data_o;
    logic [3:0]  mst_we_o;
    logic [2:0]  mst_naccess_o;
    logic        mst_valid_o;
    logic [31:0] mst_data_i = '0;
    logic        mst_valid_i = 1'b0;

    int          checks = 0;
    int          errors = 0;
    wb_req_t     exp_q[$];
    logic [31:0] rsp_q[$];

    wishbone_req_queue #(.DEPTH(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_we_i      (req_we_i),
        .req_naccess_i (req_naccess_i),
        .req_ready_o   (req_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_ready_i   (rsp_ready_i),
        .mst_addr_o    (mst_addr_o),
        .mst_data_o    (mst_data_o),
        .mst_we_o      (mst_we_o),
        .mst_naccess_o (mst_naccess_o),
        .mst_valid_o   (mst_valid_o),
        .mst_data_i    (mst_data_i),
        .mst_valid_i   (mst_valid_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Drive one push cycle from a negedge; a request is queued as expected only if ready was high.
    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                        input logic [2:0] n, output bit acc);
        req_valid_i = 1'b1;
        req_addr_i = a;
        req_data_i = d;
        req_we_i = we;
        req_naccess_i = n;
        acc = req_ready_o;
        if (acc) exp_q.push_back(wb_req_t'{a, d, we, n});
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_mst(output bit ok);
        for (int i = 0; i < 50 && !mst_valid_o; i++) @(negedge clk_i);
        ok = mst_valid_o;
    endtask

    task automatic wait_rsp(output bit ok);
        for (int i = 0; i < 50 && !rsp_valid_o; i++) @(negedge clk_i);
        ok = rsp_valid_o;
    endtask

    task automatic complete(input logic [31:0] d);
        mst_data_i = d;
        mst_valid_i = 1'b1;
        rsp_q.push_back(d);
        @(negedge clk_i);
        mst_valid_i = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    function automatic wb_req_t issued();
        return wb_req_t'{mst_addr_o, mst_data_o, mst_we_o, mst_naccess_o};
    endfunction

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({req_ready_o, mst_valid_o, rsp_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/mst_valid/rsp_valid=%b, expected 100",
                     {req_ready_o, mst_valid_o, rsp_valid_o});
        end
        checks++;
        if (rsp_data_o !== 32'h0 || issued() !== wb_req_t'(0)) begin
            errors++;
            $display("FAIL reset_data: rsp_data=%h mst=%h, expected all zero", rsp_data_o, issued());
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_single_read();
        bit acc;
        int hi;
        wb_req_t e;
        logic [31:0] ed;
        push(32'h4, 32'h0, 4'h0, 3'd1, acc);
        checks++;
        if (!acc || mst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_pre: acc=%0d mst_valid=%b, expected acc=1 mst_valid=0", acc, mst_valid_o);
        end
        @(negedge clk_i);
        e = exp_q.pop_front();
        checks++;
        if (mst_valid_o !== 1'b1 || issued() !== e) begin
            errors++;
            $display("FAIL read_issue: mst_valid=%b req=%h, expected 1 req=%h", mst_valid_o, issued(), e);
        end
        hi = 1;
        repeat (3) begin
            @(negedge clk_i);
            hi += int'(mst_valid_o);
        end
        complete(32'hDEADBEEF);
        checks++;
        if (hi != 4 || mst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL read_valid_cycles: high for %0d cycles, now %b; expected 4 then 0", hi, mst_valid_o);
        end
        ed = rsp_q.pop_front();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== ed) begin
            errors++;
            $display("FAIL read_rsp: valid=%b data=%h, expected 1 data=%h", rsp_valid_o, rsp_data_o, ed);
        end
        take_rsp();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp_clear: rsp_valid=%b, expected 0", rsp_valid_o);
        end
    endtask

    task automatic test_spurious();
        mst_data_i = 32'h12345678;
        mst_valid_i = 1'b1;
        @(negedge clk_i);
        mst_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'hDEADBEEF || mst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: rsp_valid=%b data=%h mst_valid=%b, expected 0 deadbeef 0",
                     rsp_valid_o, rsp_data_o, mst_valid_o);
        end
    endtask

    task automatic test_order();
        bit acc;
        bit ok;
        wb_req_t e;
        logic [31:0] ed;
        logic [31:0] addrs [4] = '{32'h00, 32'h04, 32'h10, 32'h14};
        for (int i = 0; i < 4; i++) push(addrs[i], 32'h11111111 * (i + 1), 4'hF, 3'(i), acc);
        for (int i = 0; i < 4; i++) begin
            wait_mst(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || issued() !== e) begin
                errors++;
                $display("FAIL order_issue[%0d]: ok=%0d req=%h, expected %h", i, ok, issued(), e);
            end
            complete(32'hA0000000 + i);
            wait_rsp(ok);
            ed = rsp_q.pop_front();
            checks++;
            if (!ok || rsp_data_o !== ed) begin
                errors++;
                $display("FAIL order_rsp[%0d]: ok=%0d data=%h, expected %h", i, ok, rsp_data_o, ed);
            end
            take_rsp();
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        bit ok;
        bit bad;
        wb_req_t e;
        logic [31:0] ed;
        push(32'h100, 32'h1, 4'h3, 3'd2, acc);
        push(32'h200, 32'h2, 4'h0, 3'd4, acc);
        wait_mst(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || issued() !== e) begin
            errors++;
            $display("FAIL bp_issue: ok=%0d req=%h, expected %h", ok, issued(), e);
        end
        complete(32'hCAFEF00D);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mst_valid_i = (i == 4);
            mst_data_i = 32'h55555555;
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hCAFEF00D || mst_valid_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: rsp_valid=%b data=%h mst_valid=%b, expected 1 cafef00d 0 throughout",
                     rsp_valid_o, rsp_data_o, mst_valid_o);
        end
        ed = rsp_q.pop_front();
        checks++;
        if (rsp_data_o !== ed) begin
            errors++;
            $display("FAIL bp_rsp: data=%h, expected %h", rsp_data_o, ed);
        end
        take_rsp();
        checks++;
        if (mst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_early: mst_valid=%b, expected 0", mst_valid_o);
        end
        @(negedge clk_i);
        e = exp_q.pop_front();
        checks++;
        if (mst_valid_o !== 1'b1 || issued() !== e) begin
            errors++;
            $display("FAIL bp_next_issue: mst_valid=%b req=%h, expected 1 %h", mst_valid_o, issued(), e);
        end
        complete(32'h0BADC0DE);
        wait_rsp(ok);
        ed = rsp_q.pop_front();
        checks++;
        if (!ok || rsp_data_o !== ed) begin
            errors++;
            $display("FAIL bp_next_rsp: ok=%0d data=%h, expected %h", ok, rsp_data_o, ed);
        end
        take_rsp();
    endtask

    task automatic test_fill();
        bit acc;
        bit ok;
        int n_acc;
        wb_req_t e;
        logic [31:0] ed;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            push(32'h1000 + 32'(i * 4), 32'hF0 + i, 4'h1, 3'd1, acc);
            n_acc += int'(acc);
        end
        checks++;
        if (n_acc != 5 || req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: accepted=%0d ready=%b, expected 5 and 0", n_acc, req_ready_o);
        end
        push(32'h2000, 32'h0, 4'h1, 3'd1, acc);
        checks++;
        if (acc || mst_valid_o !== 1'b1 || issued() !== exp_q[0]) begin
            errors++;
            $display("FAIL fill_stall: acc=%0d mst_valid=%b req=%h, expected 0 1 %h", acc, mst_valid_o, issued(), exp_q[0]);
        end
        for (int i = 0; i < 5; i++) begin
            wait_mst(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || issued() !== e) begin
                errors++;
                $display("FAIL fill_issue[%0d]: ok=%0d req=%h, expected %h", i, ok, issued(), e);
            end
            complete(32'hB0000000 + i);
            wait_rsp(ok);
            ed = rsp_q.pop_front();
            checks++;
            if (!ok || rsp_data_o !== ed) begin
                errors++;
                $display("FAIL fill_rsp[%0d]: ok=%0d data=%h, expected %h", i, ok, rsp_data_o, ed);
            end
            take_rsp();
            if (i == 0) begin
                checks++;
                if (req_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_ready_before_pop: ready=%b, expected 0", req_ready_o);
                end
                @(negedge clk_i);
                checks++;
                if (req_ready_o !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_ready_after_pop: ready=%b, expected 1", req_ready_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        bit acc;
        bit ok;
        bit bad;
        wb_req_t e;
        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i), 32'h0, 4'h0, 3'd1, acc);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (mst_valid_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_flags: mst_valid=%b ready=%b rsp_valid=%b, expected 0 1 0",
                     mst_valid_o, req_ready_o, rsp_valid_o);
        end
        checks++;
        if (dut.u_fifo.r_count !== '0) begin
            errors++;
            $display("FAIL rst_async_count: count=%0d, expected 0", dut.u_fifo.r_count);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        bad = 1'b0;
        repeat (10) begin
            mst_valid_i = 1'b1;
            mst_data_i = 32'h77777777;
            @(negedge clk_i);
            if (mst_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) bad = 1'b1;
        end
        mst_valid_i = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_no_rsp: mst_valid=%b rsp_valid=%b after reset, expected 0 0", mst_valid_o, rsp_valid_o);
        end
        push(32'h4000, 32'h9, 4'h2, 3'd3, acc);
        wait_mst(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || issued() !== e) begin
            errors++;
            $display("FAIL rst_recover: ok=%0d req=%h, expected %h", ok, issued(), e);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_spurious();
        test_order();
        test_backpressure();
        test_fill();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
